// File: rtl/accumulator_drain_scheduler.sv
// accumulator_drain_scheduler
//
// Streams every result row of a finished tile set out of the accumulator
// memory to the downstream writer. The drain shares the single accumulator
// read port with the accumulate path; the accumulate path always wins.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   start_i                  one-cycle drain request (ignored unless idle)
//   V_dim_i, U_dim_i         tile dimensions, sampled on an accepted start
//   acc_rd_req_i/addr_i      accumulate-path read request (high priority)
//   acc_rd_en_o/addr_o       muxed read port towards the accumulator memory
//   acc_rd_data_i            read data, valid one cycle after acc_rd_en_o
//   out_valid_o/ready_i      output row handshake
//   out_data_o/out_addr_o    output row payload and its row index
//   busy_o                   a drain is in progress
//   done_o                   one-cycle pulse when the drain completes
module accumulator_drain_scheduler #(
  parameter int MUL_SIZE = 32,
  parameter int ACC_W    = 32,
  parameter int ADDR_W   = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [6:0]                V_dim_i,
  input  logic [6:0]                U_dim_i,
  input  logic                      acc_rd_req_i,
  input  logic [ADDR_W-1:0]         acc_rd_addr_i,
  output logic                      acc_rd_en_o,
  output logic [ADDR_W-1:0]         acc_rd_addr_o,
  input  logic [MUL_SIZE*ACC_W-1:0] acc_rd_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [MUL_SIZE*ACC_W-1:0] out_data_o,
  output logic [ADDR_W-1:0]         out_addr_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int DW    = MUL_SIZE * ACC_W;
  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  state_e            state_r;
  state_e            state_next_s;

  logic [CNT_W-1:0]  total_rows_r;
  logic [CNT_W-1:0]  issue_cnt_r;
  logic [CNT_W-1:0]  retire_cnt_r;
  logic [3:0]        tiles_s;
  logic [CNT_W-1:0]  total_s;

  logic              inflight_r;
  logic [ADDR_W-1:0] inflight_addr_r;

  // Two-entry skid FIFO: head feeds the outputs directly, skid holds the
  // second row while the head is stalled.
  logic              head_valid_r;
  logic [DW-1:0]     head_data_r;
  logic [ADDR_W-1:0] head_addr_r;
  logic              skid_valid_r;
  logic [DW-1:0]     skid_data_r;
  logic [ADDR_W-1:0] skid_addr_r;

  logic              busy_r;
  logic              done_r;

  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic [2:0]        occ_s;
  logic [ADDR_W-1:0] issue_addr_s;
  logic              unused_dims_s;

  // Only the tile count (dimension / 32) matters; the low bits are dropped.
  assign unused_dims_s = ^{V_dim_i[4:0], U_dim_i[4:0]};
  assign tiles_s       = {2'b00, V_dim_i[6:5]} * {2'b00, U_dim_i[6:5]};
  assign total_s       = {2'b00, tiles_s, 5'b00000};

  assign issue_addr_s  = issue_cnt_r[ADDR_W-1:0];
  assign push_s        = inflight_r;
  assign pop_s         = head_valid_r & out_ready_i;

  // Occupancy seen by the issue gate counts the row leaving this cycle as
  // already gone, which is what allows one row per cycle with ready held
  // high while still never exceeding two buffered rows.
  assign occ_s = {2'b00, head_valid_r} + {2'b00, skid_valid_r}
               + {2'b00, inflight_r} - {2'b00, pop_s};

  assign out_valid_o = head_valid_r;
  assign out_data_o  = head_data_r;
  assign out_addr_o  = head_addr_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state and drain-issue decision.
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (total_s == CNT_ZERO) begin
            state_next_s = ST_FINISH;
          end else begin
            state_next_s = ST_DRAIN;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!acc_rd_req_i && (issue_cnt_r < total_rows_r) && (occ_s < 3'd2)) begin
          issue_s = 1'b1;
          if ((issue_cnt_r + CNT_ONE) == total_rows_r) begin
            state_next_s = ST_FLUSH;
          end else begin
            state_next_s = ST_DRAIN;
          end
        end else if (issue_cnt_r >= total_rows_r) begin
          state_next_s = ST_FLUSH;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        if (retire_cnt_r == total_rows_r) begin
          state_next_s = ST_FINISH;
        end else begin
          state_next_s = ST_FLUSH;
        end
      end
      ST_FINISH: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Read-port arbitration: accumulate path first, then a drain issue.
  always_comb begin
    acc_rd_en_o   = 1'b0;
    acc_rd_addr_o = {ADDR_W{1'b0}};
    if (acc_rd_req_i) begin
      acc_rd_en_o   = 1'b1;
      acc_rd_addr_o = acc_rd_addr_i;
    end else if (issue_s) begin
      acc_rd_en_o   = 1'b1;
      acc_rd_addr_o = issue_addr_s;
    end else begin
      acc_rd_en_o   = 1'b0;
      acc_rd_addr_o = {ADDR_W{1'b0}};
    end
  end

  // Row count latch plus issue and retire counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      total_rows_r <= CNT_ZERO;
      issue_cnt_r  <= CNT_ZERO;
      retire_cnt_r <= CNT_ZERO;
    end else if ((state_r == ST_IDLE) && start_i) begin
      total_rows_r <= total_s;
      issue_cnt_r  <= CNT_ZERO;
      retire_cnt_r <= CNT_ZERO;
    end else begin
      if (issue_s) begin
        issue_cnt_r <= issue_cnt_r + CNT_ONE;
      end
      if (pop_s) begin
        retire_cnt_r <= retire_cnt_r + CNT_ONE;
      end
    end
  end

  // In-flight marker: only drain-issued reads are captured on return.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_r      <= 1'b0;
      inflight_addr_r <= {ADDR_W{1'b0}};
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_addr_r <= issue_addr_s;
      end
    end
  end

  // Skid FIFO update; a push into a full FIFO cannot occur due to the issue gate.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_valid_r <= 1'b0;
      head_data_r  <= {DW{1'b0}};
      head_addr_r  <= {ADDR_W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DW{1'b0}};
      skid_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (!head_valid_r) begin
            head_valid_r <= 1'b1;
            head_data_r  <= acc_rd_data_i;
            head_addr_r  <= inflight_addr_r;
          end else begin
            skid_valid_r <= 1'b1;
            skid_data_r  <= acc_rd_data_i;
            skid_addr_r  <= inflight_addr_r;
          end
        end
        2'b01: begin
          if (skid_valid_r) begin
            head_data_r  <= skid_data_r;
            head_addr_r  <= skid_addr_r;
            skid_valid_r <= 1'b0;
          end else begin
            head_valid_r <= 1'b0;
          end
        end
        2'b11: begin
          if (skid_valid_r) begin
            head_data_r <= skid_data_r;
            head_addr_r <= skid_addr_r;
            skid_data_r <= acc_rd_data_i;
            skid_addr_r <= inflight_addr_r;
          end else begin
            head_data_r <= acc_rd_data_i;
            head_addr_r <= inflight_addr_r;
          end
        end
        default: begin
          head_valid_r <= head_valid_r;
        end
      endcase
    end
  end

  // Registered status outputs, derived from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
      done_r <= (state_next_s == ST_FINISH);
    end
  end

endmodule

// File: doc/accumulator_drain_scheduler.md
# accumulator_drain_scheduler

Sequences read-out of the accumulator memory once a matrix-multiply tile set has finished accumulating. It streams every result row to the downstream activation / unified-buffer writer over a valid/ready handshake. It shares the single accumulator read port with the accumulate path, which always wins arbitration. It sits between the accumulator control unit (its `done_o` pulse starts a drain), the accumulator memory read port, and the output writer.

## Interface
- `MUL_SIZE`, 32, systolic array edge; also the number of accumulator lanes per row.
- `ACC_W`, 32, width of one accumulator lane.
- `ADDR_W`, 10, accumulator row address width.
- `clk_i` in 1: the only clock.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: one-cycle drain request, driven from the control unit's `done_o`.
- `V_dim_i` in 7: V dimension. Sampled only on an accepted start.
- `U_dim_i` in 7: U dimension. Sampled only on an accepted start.
- `acc_rd_req_i` in 1: accumulate-path read request (high priority).
- `acc_rd_addr_i` in ADDR_W: accumulate-path read address.
- `acc_rd_en_o` out 1: muxed read enable to the accumulator memory.
- `acc_rd_addr_o` out ADDR_W: muxed read address.
- `acc_rd_data_i` in MUL_SIZE*ACC_W: read data, valid exactly 1 cycle after `acc_rd_en_o`.
- `out_valid_o` out 1: output row valid.
- `out_ready_i` in 1: downstream ready.
- `out_data_o` out MUL_SIZE*ACC_W: output row data.
- `out_addr_o` out ADDR_W: row index of `out_data_o`.
- `busy_o` out 1: a drain is in progress.
- `done_o` out 1: one-cycle pulse when the drain completes.

## Operation
- **Row count.** `total_rows = ((V_dim_i>>5)*(U_dim_i>>5))<<5`, computed 11 bits wide and latched on start. Rows are read at addresses 0 .. total_rows-1 in order.
- **States:** IDLE, DRAIN, FLUSH, FINISH.
- **IDLE.**
  - `start_i` latches the dimensions and zeroes the issue and retire counters.
  - If `total_rows==0`, go to FINISH.
  - Otherwise go to DRAIN.
  - `start_i` is ignored in any other state.
- **DRAIN.** Each cycle, drain issues a read at `issue_cnt` only when all of these hold:
  - `acc_rd_req_i==0`
  - `issue_cnt < total_rows`
  - `fifo_count + inflight < 2`

  On issue, `issue_cnt` increments. When `issue_cnt` reaches `total_rows`, go to FLUSH.
- **FLUSH.** Wait until the last row has been accepted downstream (`retire_cnt == total_rows`), then go to FINISH.
- **FINISH.** Pulse `done_o` and return to IDLE.
- **Read-port mux.**
  - `acc_rd_req_i` high: `acc_rd_en_o=1` and `acc_rd_addr_o=acc_rd_addr_i`, in every state, combinationally.
  - Else, a drain issue drives `acc_rd_en_o=1` with the drain address.
  - Else, `acc_rd_en_o=0` and `acc_rd_addr_o=0`.
- **In-flight tracking.** `inflight` is a 1-bit register, set on the cycle of a drain issue. Only drain-issued reads are captured. Accumulate-path returns are never written to the FIFO.
- **Output FIFO.**
  - 2-entry skid FIFO holding data plus address.
  - The returning row is written at the end of the cycle after its issue.
  - `out_valid_o = fifo_count!=0`. A pop happens on `out_valid_o & out_ready_i`, which increments `retire_cnt`.
  - A simultaneous push and pop leaves the count unchanged.
  - The FIFO can never overflow, because issue is gated on `fifo_count + inflight`.
- **Dimensions** are not re-read during a drain. Changes to `V_dim_i`/`U_dim_i` mid-drain have no effect.
- **Reset at any point:**
  - state returns to IDLE
  - FIFO is emptied and in-flight is cleared
  - counters are zeroed
  - a pending in-flight return is discarded

## Timing
- **Reset values:**
  - `out_valid_o` = 0
  - `busy_o` = 0
  - `done_o` = 0
  - `out_data_o` = 0
  - `out_addr_o` = 0
  - `acc_rd_en_o` follows `acc_rd_req_i` only
- **Start latency.** `start_i` in cycle 0 → DRAIN in cycle 1, first read issued in cycle 1 (if no conflict), data arrives in cycle 2, `out_valid_o` goes high in cycle 3.
- **Throughput.** With `out_ready_i` held high and no conflicts: one row per cycle. The last valid appears in cycle `total_rows+2`.
- **Completion.** `done_o` pulses 2 cycles after the final handshake (FLUSH→FINISH, then the pulse). `busy_o` is high from cycle 1 through the FINISH cycle inclusive.
- **Zero rows.** With `total_rows==0`, `done_o` pulses in cycle 1, with no reads and no valids.
- **Backpressure.** With `out_ready_i` low, at most 2 rows are buffered and issue stalls. `out_data_o`/`out_addr_o` stay stable while valid and not ready.
- **Conflicts.** Each cycle with `acc_rd_req_i` high during DRAIN delays the drain by exactly one cycle. Ordering is unaffected.

## Test plan
- **Basic drain.** V=32, U=32, ready=1, no conflicts → 32 beats at `out_addr_o` 0..31 in consecutive cycles 3..34. `done_o` pulses in cycle 36. Data matches a preloaded memory model.
- **Multi-tile drain.** V=64, U=96 → `total_rows`=192. Addresses are 0..191 in order with no gaps or duplicates. Exactly one `done_o` pulse.
- **Backpressure.** Toggle `out_ready_i` with a random 50% pattern. No beat is lost or duplicated, payload is stable while stalled, and `acc_rd_en_o` never leaves more than 2 rows outstanding.
- **Port conflict.** Assert `acc_rd_req_i` with address 0x155 in cycles 5–7 of a drain. `acc_rd_addr_o`=0x155 in those cycles, the drain resumes at the next address, and the final sequence is still complete.
- **Zero and ignored start.**
  - V=16: `done_o` pulses in cycle 1, no valids.
  - `start_i` pulsed again mid-drain: ignored, and the row count is unchanged.
- **Reset mid-drain.** Assert `rst_i` after 10 beats with the FIFO full → next cycle `out_valid_o`=0 and `busy_o`=0. A fresh start drains from address 0.
